debounce_multi: RTL



---
 rtl/debounce_multi_pkg.sv | 24 ++
 rtl/debounce_cell.sv | 73 +++++++
 rtl/debounce_multi.sv | 73 +++++++
 3 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared constants for the multi-channel pin debouncer and its CPU-visible register map.
package debounce_multi_pkg;

    localparam int DB_N_CH        = 22;
    localparam int DB_CNT_W       = 20;
    localparam int DB_THRESH_10MS = 500000;

    // Byte offsets of the debouncer registers in the peripheral window
    localparam logic [7:0] DB_REG_LEVEL    = 8'h00;
    localparam logic [7:0] DB_REG_RISE_FLG = 8'h04;
    localparam logic [7:0] DB_REG_FALL_FLG = 8'h08;
    localparam logic [7:0] DB_REG_RISE_EN  = 8'h0C;
    localparam logic [7:0] DB_REG_FALL_EN  = 8'h10;
    localparam logic [7:0] DB_REG_RISE_CLR = 8'h14;
    localparam logic [7:0] DB_REG_FALL_CLR = 8'h18;
    localparam logic [7:0] DB_REG_THRESH   = 8'h1C;

    typedef enum logic [1:0] {
        DB_EV_NONE = 2'b00,
        DB_EV_RISE = 2'b01,
        DB_EV_FALL = 2'b10
    } db_event_t;

endpackage

// File: rtl/debounce_cell.sv
// One debounced channel: synchroniser, settle counter, filtered level and edge pulses.
module debounce_cell
    import debounce_multi_pkg::*;
#(
    parameter int   CNT_W       = DB_CNT_W,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_VAL    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic [CNT_W-1:0] thresh,
    output logic             db_out,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [CNT_W-1:0]       t_m1_s;
    logic                   sync_s;
    logic                   db_r;
    logic                   db_nxt_s;
    logic                   db_prev_r;
    logic                   rise_pulse_r;
    logic                   fall_pulse_r;

    assign sync_s = sync_r[SYNC_STAGES-1];
    // A threshold of 0 behaves like 1, so the terminal count saturates at 0.
    assign t_m1_s = (thresh == CNT_ZERO) ? CNT_ZERO : (thresh - CNT_ONE);

    // Settle counter and filtered level next-state
    always_comb begin
        cnt_nxt_s = cnt_r;
        db_nxt_s  = db_r;
        if (sync_s == db_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r < t_m1_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            db_nxt_s  = sync_s;
            cnt_nxt_s = CNT_ZERO;
        end
    end

    // Synchroniser chain, counter, level and edge-pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r       <= {SYNC_STAGES{INIT_VAL}};
            cnt_r        <= CNT_ZERO;
            db_r         <= INIT_VAL;
            db_prev_r    <= INIT_VAL;
            rise_pulse_r <= 1'b0;
            fall_pulse_r <= 1'b0;
        end else begin
            sync_r       <= {sync_r[SYNC_STAGES-2:0], din};
            cnt_r        <= cnt_nxt_s;
            db_r         <= db_nxt_s;
            db_prev_r    <= db_r;
            rise_pulse_r <= db_r & ~db_prev_r;
            fall_pulse_r <= ~db_r & db_prev_r;
        end
    end

    assign db_out     = db_r;
    assign rise_pulse = rise_pulse_r;
    assign fall_pulse = fall_pulse_r;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer with polarity correction, sticky W1C edge flags and a combined irq.
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int              N_CH            = DB_N_CH,
    parameter int              CNT_W           = DB_CNT_W,
    parameter int              SYNC_STAGES     = 2,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = 22'h20_0000,
    parameter logic [N_CH-1:0] INIT_VAL        = 22'h00_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  raw_in,
    input  logic [CNT_W-1:0] thresh,
    input  logic [N_CH-1:0]  rise_en,
    input  logic [N_CH-1:0]  fall_en,
    input  logic [N_CH-1:0]  clr_rise,
    input  logic [N_CH-1:0]  clr_fall,
    output logic [N_CH-1:0]  db_out,
    output logic [N_CH-1:0]  rise_pulse,
    output logic [N_CH-1:0]  fall_pulse,
    output logic [N_CH-1:0]  rise_flag,
    output logic [N_CH-1:0]  fall_flag,
    output logic             irq
);

    logic [N_CH-1:0] pin_s;
    logic [N_CH-1:0] db_s;
    logic [N_CH-1:0] rise_pulse_s;
    logic [N_CH-1:0] fall_pulse_s;
    logic [N_CH-1:0] rise_flag_r;
    logic [N_CH-1:0] fall_flag_r;
    logic            irq_r;

    assign pin_s = raw_in ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_CH; i++) begin : g_cell
        debounce_cell #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT_VAL    (INIT_VAL[i])
        ) u_cell (
            .clk        (clk),
            .reset_n    (reset_n),
            .din        (pin_s[i]),
            .thresh     (thresh),
            .db_out     (db_s[i]),
            .rise_pulse (rise_pulse_s[i]),
            .fall_pulse (fall_pulse_s[i])
        );
    end

    // Sticky event flags (a new event beats a same-cycle clear) and the registered irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_flag_r <= {N_CH{1'b0}};
            fall_flag_r <= {N_CH{1'b0}};
            irq_r       <= 1'b0;
        end else begin
            rise_flag_r <= rise_pulse_s | (rise_flag_r & ~clr_rise);
            fall_flag_r <= fall_pulse_s | (fall_flag_r & ~clr_fall);
            irq_r       <= |((rise_flag_r & rise_en) | (fall_flag_r & fall_en));
        end
    end

    assign db_out     = db_s;
    assign rise_pulse = rise_pulse_s;
    assign fall_pulse = fall_pulse_s;
    assign rise_flag  = rise_flag_r;
    assign fall_flag  = fall_flag_r;
    assign irq        = irq_r;

endmodule
